// File: rtl/pipeline_issue_unit.sv
// Issue stage: buffers packed instruction words in a small FIFO and issues them in order,
// inserting bubbles while a source register is still being written by a recent issue.
module pipeline_issue_unit #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned HAZ_WIN = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_instr,
   input  logic        pipe_hold,
   input  logic        flush,
   output logic        issue_valid,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  rd,
   output logic [3:0]  func,
   output logic [7:0]  addr,
   output logic [15:0] issue_count,
   output logic [15:0] bubble_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   logic [23:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   logic          r_sb_v  [HAZ_WIN];
   logic [3:0]    r_sb_rd [HAZ_WIN];

   logic          r_issue_valid;
   logic [3:0]    r_rs1, r_rs2, r_rd, r_func;
   logic [7:0]    r_addr;
   logic [15:0]   r_issue_count;
   logic [15:0]   r_bubble_count;

   logic [23:0]   w_head;
   logic          w_has_head;
   logic          w_full;
   logic          w_hazard;
   logic          w_push;
   logic          w_issue;
   logic          w_bubble;

   assign w_head     = r_mem[r_rptr];
   assign w_has_head = (r_count != '0);
   assign w_full     = (r_count == CNT_FULL);
   assign in_ready   = !w_full;

   always_comb begin
      w_hazard = 1'b0;
      for (int unsigned i = 0; i < HAZ_WIN; i++) begin
         if (r_sb_v[i] && ((r_sb_rd[i] == w_head[15:12]) || (r_sb_rd[i] == w_head[11:8])))
            w_hazard = 1'b1;
      end
      w_hazard = w_hazard && w_has_head;
   end

   assign w_push   = in_valid && !w_full && !flush;
   assign w_issue  = w_has_head && !pipe_hold && !w_hazard && !flush;
   assign w_bubble = w_has_head && !pipe_hold && !flush && w_hazard;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= in_instr;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_issue)
            r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Shifts every cycle; a non-issue cycle enters as an invalid slot so the window ages out.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int unsigned i = 0; i < HAZ_WIN; i++) begin
            r_sb_v[i]  <= 1'b0;
            r_sb_rd[i] <= '0;
         end
      end else begin
         r_sb_v[0]  <= w_issue;
         r_sb_rd[0] <= w_head[19:16];
         for (int unsigned i = 1; i < HAZ_WIN; i++) begin
            r_sb_v[i]  <= r_sb_v[i-1];
            r_sb_rd[i] <= r_sb_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_issue_valid  <= 1'b0;
         r_func         <= '0;
         r_rd           <= '0;
         r_rs1          <= '0;
         r_rs2          <= '0;
         r_addr         <= '0;
         r_issue_count  <= '0;
         r_bubble_count <= '0;
      end else begin
         r_issue_valid <= w_issue;
         if (w_issue) begin
            r_func        <= w_head[23:20];
            r_rd          <= w_head[19:16];
            r_rs1         <= w_head[15:12];
            r_rs2         <= w_head[11:8];
            r_addr        <= w_head[7:0];
            r_issue_count <= r_issue_count + 16'd1;
         end
         if (w_bubble)
            r_bubble_count <= r_bubble_count + 16'd1;
      end
   end

   assign issue_valid  = r_issue_valid;
   assign func         = r_func;
   assign rd           = r_rd;
   assign rs1          = r_rs1;
   assign rs2          = r_rs2;
   assign addr         = r_addr;
   assign issue_count  = r_issue_count;
   assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_pipeline_issue_unit.sv
// Bench for pipeline_issue_unit: directed scenarios plus random traffic, all checked against
// a queue-based model that tracks hazards by the edge number of each register's last issue.
module tb_pipeline_issue_unit;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned HAZ_WIN = 2;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_instr;
   logic        pipe_hold;
   logic        flush;
   logic        issue_valid;
   logic [3:0]  rs1, rs2, rd, func;
   logic [7:0]  addr;
   logic [15:0] issue_count;
   logic [15:0] bubble_count;

   pipeline_issue_unit #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .pipe_hold(pipe_hold), .flush(flush),
      .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func),
      .addr(addr), .issue_count(issue_count), .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [23:0] mq[$];
   int          last_edge [16];
   int          n_edge = 0;
   logic        m_valid;
   logic [23:0] m_fields;
   logic [15:0] m_ic, m_bc;
   int          iss_edges[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n_edge);
      end
   endtask

   function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int a);
      logic [3:0] f4, d4, a4, b4;
      logic [7:0] a8;
      f4 = 4'(f); d4 = 4'(d); a4 = 4'(s1); b4 = 4'(s2); a8 = 8'(a);
      return {f4, d4, a4, b4, a8};
   endfunction

   function automatic bit recent(input logic [3:0] r);
      int d;
      d = n_edge - last_edge[r];
      return (d >= 1) && (d <= int'(HAZ_WIN));
   endfunction

   task automatic clear_sb();
      for (int i = 0; i < 16; i++) last_edge[i] = -100;
   endtask

   task automatic model_edge();
      bit has, haz, iss, full;
      logic [23:0] head;
      n_edge++;
      if (reset) begin
         mq.delete();
         clear_sb();
         m_valid = 1'b0; m_fields = '0; m_ic = '0; m_bc = '0;
      end else begin
         has  = (mq.size() > 0);
         head = has ? mq[0] : 24'h0;
         haz  = has && (recent(head[15:12]) || recent(head[11:8]));
         full = (mq.size() == DEPTH);
         iss  = has && !pipe_hold && !haz && !flush;
         if (has && !pipe_hold && !flush && haz) m_bc++;
         m_valid = iss;
         if (flush) begin
            mq.delete();
            clear_sb();
         end else begin
            if (iss) begin
               void'(mq.pop_front());
               m_fields = head;
               last_edge[head[19:16]] = n_edge;
               m_ic++;
            end
            if (in_valid && !full) mq.push_back(in_instr);
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      if (issue_valid === 1'b1) iss_edges.push_back(n_edge);
      check("issue_valid", 32'(issue_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("fields", {8'h0, func, rd, rs1, rs2, addr}, {8'h0, m_fields});
      check("issue_count", 32'(issue_count), 32'(m_ic));
      check("bubble_count", 32'(bubble_count), 32'(m_bc));
   endtask

   task automatic drive(input bit v, input logic [23:0] w, input bit hold, input bit fl);
      in_valid = v; in_instr = w; pipe_hold = hold; flush = fl;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] bc0;
      logic [3:0]  rr, r1, r2;
      reset = 1'b1; in_valid = 1'b1; in_instr = mk(1, 2, 3, 4, 5); pipe_hold = 1'b0; flush = 1'b0;
      clear_sb();

      // 1: reset with in_valid high
      tick(); tick();
      check("s1_ready", 32'(in_ready), 32'd1);
      check("s1_ic", 32'(issue_count), 32'd0);
      reset = 1'b0;
      drive(1'b0, 24'h0, 1'b0, 1'b0);
      check("s1_nothing_issued", 32'(issue_valid), 32'd0);

      // 2: independent back-to-back
      iss_edges.delete();
      drive(1'b1, mk(0, 10, 3, 5, 125), 1'b0, 1'b0);
      drive(1'b1, mk(2, 12, 3, 8, 126), 1'b0, 1'b0);
      idle(3);
      check("s2_ic", 32'(issue_count), 32'd2);
      check("s2_bc", 32'(bubble_count), 32'd0);
      check("s2_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd1);

      // 3: RAW on rs1, then on rs2
      for (int k = 0; k < 2; k++) begin
         iss_edges.delete();
         bc0 = bubble_count;
         drive(1'b1, mk(0, 10, 3, 5, 125), 1'b0, 1'b0);
         drive(1'b1, (k == 0) ? mk(1, 14, 10, 5, 128) : mk(1, 14, 3, 10, 128), 1'b0, 1'b0);
         idle(6);
         check("s3_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd3);
         check("s3_bubbles", 32'(bubble_count - bc0), 32'd2);
      end

      // 4: fill under hold, then drain
      bc0 = bubble_count;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, mk(i, i, 8, 9, 200 + i), 1'b1, 1'b0);
         if (i == 3) check("s4_full", 32'(in_ready), 32'd0);
      end
      iss_edges.delete();
      idle(6);
      check("s4_drained", 32'(iss_edges.size()), 32'd4);
      check("s4_nogap", 32'(iss_edges[3] - iss_edges[0]), 32'd3);
      check("s4_bc", 32'(bubble_count - bc0), 32'd0);

      // 5: flush with buffered words, then consumer of r13 issues with no bubbles
      drive(1'b1, mk(3, 13, 0, 1, 10), 1'b0, 1'b0);
      drive(1'b1, mk(4, 5, 0, 1, 11), 1'b0, 1'b0);
      drive(1'b1, mk(4, 6, 0, 1, 12), 1'b1, 1'b0);
      drive(1'b1, mk(4, 7, 0, 1, 13), 1'b1, 1'b0);
      drive(1'b1, mk(9, 9, 9, 9, 99), 1'b0, 1'b1);
      check("s5_flush_iv", 32'(issue_valid), 32'd0);
      bc0 = bubble_count;
      drive(1'b1, mk(5, 2, 13, 13, 77), 1'b0, 1'b0);
      drive(1'b0, 24'h0, 1'b0, 1'b0);
      check("s5_issue", 32'(issue_valid), 32'd1);
      check("s5_bc", 32'(bubble_count - bc0), 32'd0);
      idle(3);

      // 6: reset mid-stream with hazard pending
      drive(1'b1, mk(1, 7, 0, 0, 1), 1'b0, 1'b0);
      drive(1'b1, mk(2, 8, 7, 0, 2), 1'b0, 1'b0);
      drive(1'b1, mk(3, 9, 0, 0, 3), 1'b0, 1'b0);
      reset = 1'b1;
      drive(1'b1, mk(6, 6, 6, 6, 6), 1'b0, 1'b0);
      reset = 1'b0;
      check("s6_ic", 32'(issue_count), 32'd0);
      check("s6_bc", 32'(bubble_count), 32'd0);
      iss_edges.delete();
      drive(1'b1, mk(0, 10, 3, 5, 125), 1'b0, 1'b0);
      drive(1'b1, mk(2, 12, 3, 8, 126), 1'b0, 1'b0);
      idle(3);
      check("s6_ic2", 32'(issue_count), 32'd2);
      check("s6_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         rr = 4'($urandom_range(0, 5));
         r1 = 4'($urandom_range(0, 5));
         r2 = 4'($urandom_range(0, 5));
         drive($urandom_range(0, 99) < 70, {4'($urandom), rr, r1, r2, 8'($urandom)},
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 2);
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
